// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for alu_op_sequencer.
//   alu_op_e    - command opcode (ADD, SUB, MUL, DIV)
//   seq_state_e - sequencer FSM state
//   ONES_ZERO_* - the two one's-complement encodings of zero
//   lat_of()    - hold latency for an opcode, in cycles
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [14:0] ONES_ZERO_POS = 15'h0000;
    localparam logic [14:0] ONES_ZERO_NEG = 15'h7FFF;

    // Add/sub is combinational and needs a single cycle; mult/div
    // latencies come from the instantiating block's parameters.
    function automatic logic [3:0] lat_of(alu_op_e op, int mul_lat, int div_lat);
        case (op)
            MUL:     lat_of = 4'(mul_lat);
            DIV:     lat_of = 4'(div_lat);
            default: lat_of = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/ones_comp_add_sub.sv
// ones_comp_add_sub: one's-complement adder/subtractor with end-around carry.
//   x, y - operands
//   sub  - 1: x - y (adds ~y), 0: x + y
//   sum  - result; -0 is returned as produced
module ones_comp_add_sub #(
    parameter int NUM_BIT = 15
) (
    input  logic [NUM_BIT-1:0] x,
    input  logic [NUM_BIT-1:0] y,
    input  logic               sub,
    output logic [NUM_BIT-1:0] sum
);

    logic [NUM_BIT-1:0] y_eff;
    logic [NUM_BIT:0]   raw;

    assign y_eff = sub ? ~y : y;
    assign raw   = {1'b0, x} + {1'b0, y_eff};
    // Folding the carry back in cannot generate a second carry.
    assign sum   = raw[NUM_BIT-1:0] + {{(NUM_BIT-1){1'b0}}, raw[NUM_BIT]};

endmodule

// File: rtl/ones_comp_div.sv
// ones_comp_div: one's-complement divider, 2*NUM_BIT-bit numerator.
//   num, den   - numerator / denominator
//   q, r       - quotient (truncated toward zero), remainder (sign of num)
//   uf_n, uf_d - operand was -0 and lost its sign converting to magnitude
// A zero denominator yields q=r=0; callers are expected to flag it.
module ones_comp_div #(
    parameter int NUM_BIT = 15
) (
    input  logic [2*NUM_BIT-1:0] num,
    input  logic [NUM_BIT-1:0]   den,
    output logic [NUM_BIT-1:0]   q,
    output logic [NUM_BIT-1:0]   r,
    output logic                 uf_n,
    output logic                 uf_d
);

    logic                 sn, sd;
    logic [2*NUM_BIT-2:0] mn, md, qf, rf;

    assign sn = num[2*NUM_BIT-1];
    assign sd = den[NUM_BIT-1];
    assign mn = sn ? ~num[2*NUM_BIT-2:0] : num[2*NUM_BIT-2:0];
    assign md = {{NUM_BIT{1'b0}}, (sd ? ~den[NUM_BIT-2:0] : den[NUM_BIT-2:0])};
    assign qf = (md == '0) ? '0 : mn / md;
    assign rf = (md == '0) ? '0 : mn % md;

    // Quotients beyond NUM_BIT-1 magnitude bits are truncated.
    assign q = (sn ^ sd) ? ~{1'b0, qf[NUM_BIT-2:0]} : {1'b0, qf[NUM_BIT-2:0]};
    assign r = sn ? ~{1'b0, rf[NUM_BIT-2:0]} : {1'b0, rf[NUM_BIT-2:0]};

    assign uf_n = sn && (mn == '0);
    assign uf_d = sd && (md == '0);

endmodule

// File: rtl/ones_comp_mult.sv
// ones_comp_mult: one's-complement multiplier, 2*NUM_BIT-bit product.
//   x, y       - operands
//   p          - product, one's complement
//   uf_x, uf_y - operand was -0 and lost its sign converting to magnitude
module ones_comp_mult #(
    parameter int NUM_BIT = 15
) (
    input  logic [NUM_BIT-1:0]   x,
    input  logic [NUM_BIT-1:0]   y,
    output logic [2*NUM_BIT-1:0] p,
    output logic                 uf_x,
    output logic                 uf_y
);

    logic               sx, sy;
    logic [2*NUM_BIT-3:0] mx, my, pm;

    assign sx = x[NUM_BIT-1];
    assign sy = y[NUM_BIT-1];
    assign mx = {{(NUM_BIT-1){1'b0}}, (sx ? ~x[NUM_BIT-2:0] : x[NUM_BIT-2:0])};
    assign my = {{(NUM_BIT-1){1'b0}}, (sy ? ~y[NUM_BIT-2:0] : y[NUM_BIT-2:0])};
    assign pm = mx * my;
    assign p  = (sx ^ sy) ? ~{2'b00, pm} : {2'b00, pm};

    assign uf_x = sx && (mx == '0);
    assign uf_y = sy && (my == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: single-issue controller sharing the one's-complement
// add/sub, multiply and divide units.
//   clk, rst_n         - clock, async active-low reset
//   cmd_valid/ready    - command handshake; cmd_op, cmd_a, cmd_b sampled on accept
//   rsp_valid/ready    - response handshake
//   rsp_hi, rsp_lo     - MUL product hi/lo, DIV quotient/remainder, ADD/SUB 0/sum
//   rsp_underflow      - active unit's -0 conversion flags
//   rsp_div_zero       - DIV by +0 or -0
//   busy               - not idle
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_BIT = 15,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [2*NUM_BIT-1:0] cmd_a,
    input  logic [NUM_BIT-1:0]   cmd_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NUM_BIT-1:0]   rsp_hi,
    output logic [NUM_BIT-1:0]   rsp_lo,
    output logic                 rsp_underflow,
    output logic                 rsp_div_zero,
    output logic                 busy
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("MUL_LAT must be within 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
        $error("DIV_LAT must be within 1..15");
    end

    seq_state_e           state;
    logic [3:0]           cnt;
    alu_op_e              op_r;
    logic [2*NUM_BIT-1:0] a_r;
    logic [NUM_BIT-1:0]   b_r;
    logic                 dz_r;

    // Command decode at the accept edge.
    alu_op_e    cmd_op_e;
    logic       cmd_dz;
    logic [3:0] cmd_cnt;

    assign cmd_op_e = alu_op_e'(cmd_op);
    assign cmd_dz   = (cmd_op_e == DIV) && ((cmd_b == '0) || (&cmd_b));
    // A zero divisor skips the divider wait entirely.
    assign cmd_cnt  = cmd_dz ? 4'd0 : lat_of(cmd_op_e, MUL_LAT, DIV_LAT) - 4'd1;

    // Unit inputs: only the selected unit sees the operands.
    logic [NUM_BIT-1:0]   as_x, as_y, mu_x, mu_y, dv_den;
    logic [2*NUM_BIT-1:0] dv_num;
    logic                 as_sub;

    always_comb begin
        as_x   = '0;
        as_y   = '0;
        as_sub = 1'b0;
        mu_x   = '0;
        mu_y   = '0;
        dv_num = '0;
        dv_den = '0;
        if (state == EXEC) begin
            case (op_r)
                ADD, SUB: begin
                    as_x   = a_r[NUM_BIT-1:0];
                    as_y   = b_r;
                    as_sub = (op_r == SUB);
                end
                MUL: begin
                    mu_x = a_r[NUM_BIT-1:0];
                    mu_y = b_r;
                end
                default: begin
                    dv_num = a_r;
                    dv_den = b_r;
                end
            endcase
        end
    end

    logic [NUM_BIT-1:0]   as_sum, dv_q, dv_r;
    logic [2*NUM_BIT-1:0] mu_p;
    logic                 mu_uf_x, mu_uf_y, dv_uf_n, dv_uf_d;

    ones_comp_add_sub #(.NUM_BIT(NUM_BIT)) u_add_sub (
        .x(as_x), .y(as_y), .sub(as_sub), .sum(as_sum)
    );

    ones_comp_mult #(.NUM_BIT(NUM_BIT)) u_mult (
        .x(mu_x), .y(mu_y), .p(mu_p), .uf_x(mu_uf_x), .uf_y(mu_uf_y)
    );

    ones_comp_div #(.NUM_BIT(NUM_BIT)) u_div (
        .num(dv_num), .den(dv_den), .q(dv_q), .r(dv_r), .uf_n(dv_uf_n), .uf_d(dv_uf_d)
    );

    // Result selection for the capture cycle.
    logic [NUM_BIT-1:0] res_hi, res_lo;
    logic               res_uf;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_uf = 1'b0;
        case (op_r)
            ADD, SUB: res_lo = as_sum;
            MUL: begin
                res_hi = mu_p[2*NUM_BIT-1:NUM_BIT];
                res_lo = mu_p[NUM_BIT-1:0];
                res_uf = mu_uf_x | mu_uf_y;
            end
            default: begin
                if (!dz_r) begin
                    res_hi = dv_q;
                    res_lo = dv_r;
                    res_uf = dv_uf_n | dv_uf_d;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            op_r          <= ADD;
            a_r           <= '0;
            b_r           <= '0;
            dz_r          <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_hi        <= '0;
            rsp_lo        <= '0;
            rsp_underflow <= 1'b0;
            rsp_div_zero  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op_e;
                        a_r       <= cmd_a;
                        b_r       <= cmd_b;
                        dz_r      <= cmd_dz;
                        cnt       <= cmd_cnt;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_hi        <= res_hi;
                        rsp_lo        <= res_lo;
                        rsp_underflow <= res_uf;
                        rsp_div_zero  <= dz_r;
                        rsp_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // cmd_ready rises with the return to IDLE, so a waiting
                    // command is taken one cycle after the response leaves.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Single-issue controller that shares the one's-complement arithmetic units between requesters: ones_comp_add_sub, ones_comp_mult and ones_comp_div. It accepts one command through a valid/ready handshake and registers the operands. It then holds the selected unit's inputs stable for that unit's fixed latency, captures the result and presents it through a second valid/ready handshake. It sits between the instruction-sequencing logic and the combinational/pipelined ALU units.

Parameters:
NUM_BIT, 15, one's-complement word width
MUL_LAT, 2, cycles the multiplier inputs must be held before the product is valid (1..15)
DIV_LAT, 6, cycles the divider inputs must be held before quotient/remainder are valid (1..15)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  0=ADD, 1=SUB, 2=MUL, 3=DIV
cmd_a  in  2*NUM_BIT  DIV: 30-bit numerator; others: operand x in [NUM_BIT-1:0], upper bits ignored
cmd_b  in  NUM_BIT  operand y / denominator
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_hi  out  NUM_BIT  MUL: product[29:15]; DIV: quotient; ADD/SUB: 0
rsp_lo  out  NUM_BIT  MUL: product[14:0]; DIV: remainder; ADD/SUB: sum
rsp_underflow  out  1  OR of the active unit's conversion underflow flags (0 for ADD/SUB)
rsp_div_zero  out  1  DIV with denominator +0 (0x0000) or -0 (0x7FFF)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - All operand/result registers = 0.
  - cmd_ready=1 once out of reset; rsp_valid=0, rsp_hi=rsp_lo=0, flags=0, busy=0.
  - Reset mid-operation discards the in-flight command; no response is ever produced for it.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge k: latch op, a, b; load counter with LAT-1, where LAT = 1 for ADD/SUB, MUL_LAT for MUL, DIV_LAT for DIV; go to EXEC.
- DIV with zero denominator (either zero): LAT forced to 1; the divider result is ignored; at capture rsp_hi=rsp_lo=0, rsp_div_zero=1, rsp_underflow=0.
- EXEC:
  - Latched operands drive the selected unit; unselected units' inputs are held at 0 to save toggling.
  - Counter decrements each cycle.
  - In the cycle counter==0: capture the unit outputs into the rsp registers and go to DONE.
  - Net latency: rsp_valid is first high in cycle k+LAT+1 after the accept edge k.
- DONE:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0, for an unbounded time.
  - On rsp_valid&&rsp_ready: go to IDLE; rsp_valid drops next cycle.
  - Result registers keep their last value (not cleared).
- cmd_ready is 0 in EXEC and DONE.
  - A command presented during DONE is not accepted in the same cycle as the response handshake; cmd_ready returns the following cycle.
  - Throughput is one command per LAT+2 cycles minimum.
- Arithmetic:
  - All values are one's complement.
  - ADD/SUB use end-around carry; -0 results are returned as produced (no normalisation).
  - DIV quotient truncates toward zero; remainder takes the sign of the numerator.
- Counter is 4 bits. Elaboration fails (assertion) if MUL_LAT or DIV_LAT is outside 1..15.
- cmd_* are sampled only on the accept edge; changes after acceptance have no effect.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_e enum (ADD, SUB, MUL, DIV; 2 bits)
  - seq_state_e enum (IDLE, EXEC, DONE)
  - constants ONES_ZERO_POS=15'h0000 and ONES_ZERO_NEG=15'h7FFF
  - a function lat_of(op) returning the latency value.
- The three existing units are instantiated unchanged inside the block; no new sub-module is needed beyond them.

Test Plan:
1. ADD, a=0x0005, b=0x0003 -> after 2 cycles rsp_lo=0x0008, rsp_hi=0, flags 0; cmd_ready low during EXEC/DONE.
2. SUB, a=0x0005, b=0x0003 -> rsp_lo=0x0002 (end-around carry taken); ADD 0x0005+0x7FFA -> rsp_lo=0x7FFF (-0 preserved).
3. MUL, a=0x0003, b=0x7FFD (-2), MUL_LAT=2 -> rsp_valid at k+3; rsp_hi=0x7FFF, rsp_lo=0x7FF9 (-6); rsp_ready held low 5 cycles -> outputs stable throughout.
4. DIV, a=30'd100, b=0x0007, DIV_LAT=6 -> rsp_valid at k+7; rsp_hi=0x000E, rsp_lo=0x0002. DIV with b=0x7FFF -> rsp_valid at k+2, rsp_div_zero=1, rsp_hi=rsp_lo=0.
5. Back-to-back: cmd_valid held high with ADD then MUL, rsp_ready tied 1 -> second accept exactly one cycle after the first response handshake; both results correct, in order.
6. Assert rst_n=0 asynchronously mid-EXEC of a DIV -> all outputs 0 immediately; after release cmd_ready=1 and no stale rsp_valid.
